// File: rtl/shazam_pkg.sv
// Shared constants and types for the shazam_core capture path.
package shazam_pkg;

    localparam int ADC_WIDTH          = 12;
    localparam int FFT_LENGTH_DEFAULT = 1024;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ENGINE,
        FILL
    } dispatch_state_t;

endpackage

// File: rtl/frame_dispatcher_rr_pointer.sv
// engine_rr_pointer: modulo-NUM_ENGINES round-robin index with one-hot decode.
module engine_rr_pointer #(
    parameter int NUM_ENGINES = 3,
    parameter int IDX_W       = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   advance,
    output logic [IDX_W-1:0]       idx,
    output logic [NUM_ENGINES-1:0] onehot
);

    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q <= '0;
        end else if (advance) begin
            if (idx_q == IDX_W'(NUM_ENGINES - 1)) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            onehot[i] = (idx_q == IDX_W'(i));
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/frame_dispatcher.sv
// Frames the ADC stream and hands whole frames round-robin to the FFT engines.
// Optional FRAME_DROP_CNT_EN adds a saturating drop_count output.
module frame_dispatcher
    import shazam_pkg::*;
#(
    parameter int DATA_WIDTH  = ADC_WIDTH,
    parameter int FFT_LENGTH  = FFT_LENGTH_DEFAULT,
    parameter int NUM_ENGINES = 3,
    localparam int ADDR_W     = $clog2(FFT_LENGTH),
    localparam int IDX_W      = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [DATA_WIDTH-1:0]  adc_data,
    input  logic                   adc_data_valid,
    input  logic                   start,
    input  logic [NUM_ENGINES-1:0] engine_ready,
    output logic [DATA_WIDTH-1:0]  wr_data,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [NUM_ENGINES-1:0] wr_en,
    output logic [NUM_ENGINES-1:0] frame_done,
    output logic [IDX_W-1:0]       active_engine,
    output logic                   busy
`ifdef FRAME_DROP_CNT_EN
    ,
    output logic [15:0]            drop_count
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FFT_LENGTH - 1);

    dispatch_state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NUM_ENGINES-1:0] onehot;
    logic cur_ready;
    logic accept;
    logic last;
    logic drop;

    engine_rr_pointer #(
        .NUM_ENGINES(NUM_ENGINES),
        .IDX_W      (IDX_W)
    ) u_ptr (
        .clk    (clk),
        .reset_n(reset_n),
        .advance(last),
        .idx    (active_engine),
        .onehot (onehot)
    );

    // Readiness only matters when a frame is about to start.
    assign cur_ready = |(engine_ready & onehot);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        accept  = 1'b0;
        last    = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = WAIT_ENGINE;
            end
            WAIT_ENGINE: begin
                if (!start) begin
                    state_d = IDLE;
                end else if (adc_data_valid) begin
                    if (cur_ready) begin
                        accept  = 1'b1;
                        addr_d  = ADDR_W'(1);
                        state_d = FILL;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            FILL: begin
                if (adc_data_valid) begin
                    accept = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        last    = 1'b1;
                        addr_d  = '0;
                        state_d = WAIT_ENGINE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wr_data    <= '0;
            wr_addr    <= '0;
            wr_en      <= '0;
            frame_done <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_en      <= accept ? onehot : '0;
            frame_done <= last ? onehot : '0;
            if (accept) begin
                wr_data <= adc_data;
                wr_addr <= addr_q;
            end
        end
    end

    assign busy = (state_q != IDLE);

`ifdef FRAME_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_dispatcher.sv
// Directed bench for frame_dispatcher (8/3 and 4/1 configurations).
module tb_frame_dispatcher;

    logic        clk;
    logic        reset_n;
    logic [11:0] adc_data;
    logic        adc_data_valid;
    logic        start;
    logic [2:0]  engine_ready;

    logic [11:0] wr_data3;
    logic [2:0]  wr_addr3;
    logic [2:0]  wr_en3;
    logic [2:0]  done3;
    logic [1:0]  act3;
    logic        busy3;

    logic [11:0] wr_data1;
    logic [1:0]  wr_addr1;
    logic [0:0]  wr_en1;
    logic [0:0]  done1;
    logic [0:0]  act1;
    logic        busy1;

`ifdef FRAME_DROP_CNT_EN
    logic [15:0] drop3;
    logic [15:0] drop1;
`endif

    int checks = 0;
    int errors = 0;

    frame_dispatcher #(
        .DATA_WIDTH (12),
        .FFT_LENGTH (8),
        .NUM_ENGINES(3)
    ) dut3 (
        .clk           (clk),
        .reset_n       (reset_n),
        .adc_data      (adc_data),
        .adc_data_valid(adc_data_valid),
        .start         (start),
        .engine_ready  (engine_ready),
        .wr_data       (wr_data3),
        .wr_addr       (wr_addr3),
        .wr_en         (wr_en3),
        .frame_done    (done3),
        .active_engine (act3),
        .busy          (busy3)
`ifdef FRAME_DROP_CNT_EN
        ,
        .drop_count    (drop3)
`endif
    );

    frame_dispatcher #(
        .DATA_WIDTH (12),
        .FFT_LENGTH (4),
        .NUM_ENGINES(1)
    ) dut1 (
        .clk           (clk),
        .reset_n       (reset_n),
        .adc_data      (adc_data),
        .adc_data_valid(adc_data_valid),
        .start         (start),
        .engine_ready  (engine_ready[0]),
        .wr_data       (wr_data1),
        .wr_addr       (wr_addr1),
        .wr_en         (wr_en1),
        .frame_done    (done1),
        .active_engine (act1),
        .busy          (busy1)
`ifdef FRAME_DROP_CNT_EN
        ,
        .drop_count    (drop1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [11:0] d;
        logic [2:0]  rdy;
        logic [2:0]  en;
        logic [2:0]  addr;
        logic [2:0]  done;
        logic [1:0]  act;
    } vec_t;

    vec_t tbl[24];

    task automatic cyc(input logic rn, input logic st, input logic v,
                       input logic [11:0] d, input logic [2:0] r);
        reset_n        = rn;
        start          = st;
        adc_data_valid = v;
        adc_data       = d;
        engine_ready   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    initial begin
        int pulses;

        // Stream of 24 back-to-back samples: three frames to engines 0,1,2.
        for (int i = 0; i < 24; i++) begin
            tbl[i].vld  = 1'b1;
            tbl[i].d    = 12'(i);
            tbl[i].rdy  = 3'b111;
            tbl[i].en   = 3'(1 << (i / 8));
            tbl[i].addr = 3'(i % 8);
            tbl[i].done = (i % 8 == 7) ? 3'(1 << (i / 8)) : 3'b000;
            tbl[i].act  = (i % 8 == 7) ? 2'(((i / 8) + 1) % 3) : 2'(i / 8);
        end

        // Reset held, then released with start low and samples present.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 12'h5A5, 3'b111);
        chk("rst_busy", 32'(busy3), 32'd0);
        chk("rst_wr_en", 32'(wr_en3), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b1, 12'(i + 5), 3'b111);
            chk("idle_wr_en", 32'(wr_en3), 32'd0);
            chk("idle_busy", 32'(busy3), 32'd0);
            chk("idle_done", 32'(done3), 32'd0);
            chk("idle_addr", 32'(wr_addr3), 32'd0);
            chk("idle_data", 32'(wr_data3), 32'd0);
            chk("idle_act", 32'(act3), 32'd0);
        end

        // Table-driven lossless streaming across frame boundaries.
        cyc(1'b1, 1'b1, 1'b0, 12'd0, 3'b111);
        chk("wait_busy", 32'(busy3), 32'd1);
        for (int i = 0; i < 24; i++) begin
            cyc(1'b1, 1'b1, tbl[i].vld, tbl[i].d, tbl[i].rdy);
            chk("tbl_wr_en", 32'(wr_en3), 32'(tbl[i].en));
            chk("tbl_addr", 32'(wr_addr3), 32'(tbl[i].addr));
            chk("tbl_data", 32'(wr_data3), 32'(tbl[i].d));
            chk("tbl_done", 32'(done3), 32'(tbl[i].done));
            chk("tbl_act", 32'(act3), 32'(tbl[i].act));
        end

        // Engine 1 not ready: five samples dropped, then its frame starts.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b1, 12'(100 + i), 3'b111);
        chk("f0_act", 32'(act3), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 12'(300 + i), 3'b101);
            chk("drop_wr_en", 32'(wr_en3), 32'd0);
            chk("drop_busy", 32'(busy3), 32'd1);
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 12'(200 + i), 3'b111);
            chk("e1_wr_en", 32'(wr_en3), 32'd2);
            chk("e1_addr", 32'(wr_addr3), 32'(i));
            chk("e1_data", 32'(wr_data3), 32'(200 + i));
            chk("e1_done", 32'(done3), (i == 7) ? 32'd2 : 32'd0);
        end
`ifdef FRAME_DROP_CNT_EN
        chk("drop_count", 32'(drop3), 32'd5);
`endif

        // start falls mid-frame: frame still completes, then back to IDLE.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, (i < 4), 1'b1, 12'(400 + i), 3'b111);
            chk("stop_wr_en", 32'(wr_en3), 32'd4);
            chk("stop_addr", 32'(wr_addr3), 32'(i));
            chk("stop_done", 32'(done3), (i == 7) ? 32'd4 : 32'd0);
        end
        chk("stop_act", 32'(act3), 32'd0);
        chk("stop_busy_wait", 32'(busy3), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 12'd0, 3'b111);
        chk("stop_busy_idle", 32'(busy3), 32'd0);
        chk("stop_no_wr", 32'(wr_en3), 32'd0);
`ifdef FRAME_DROP_CNT_EN
        chk("stop_drop_count", 32'(drop3), 32'd5);
`endif

        // Reset during a partial frame to engine 1.
        cyc(1'b1, 1'b1, 1'b0, 12'd0, 3'b111);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b1, 12'(500 + i), 3'b111);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 12'(550 + i), 3'b111);
            chk("part_wr_en", 32'(wr_en3), 32'd2);
        end
        cyc(1'b0, 1'b1, 1'b1, 12'd999, 3'b111);
        chk("mrst_done", 32'(done3), 32'd0);
        chk("mrst_wr_en", 32'(wr_en3), 32'd0);
        chk("mrst_act", 32'(act3), 32'd0);
        chk("mrst_busy", 32'(busy3), 32'd0);
`ifdef FRAME_DROP_CNT_EN
        chk("mrst_drop_count", 32'(drop3), 32'd0);
`endif
        cyc(1'b1, 1'b1, 1'b0, 12'd0, 3'b111);
        cyc(1'b1, 1'b1, 1'b1, 12'd600, 3'b111);
        chk("restart_wr_en", 32'(wr_en3), 32'd1);
        chk("restart_addr", 32'(wr_addr3), 32'd0);
        chk("restart_data", 32'(wr_data3), 32'd600);

        // Single engine, 4-sample frames.
        cyc(1'b0, 1'b0, 1'b0, 12'd0, 3'b111);
        cyc(1'b1, 1'b1, 1'b0, 12'd0, 3'b111);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 12'(700 + i), 3'b111);
            if (done1 == 1'b1) pulses++;
            chk("one_wr_en", 32'(wr_en1), 32'd1);
            chk("one_addr", 32'(wr_addr1), 32'(i % 4));
            chk("one_data", 32'(wr_data1), 32'(700 + i));
            chk("one_done", 32'(done1), (i % 4 == 3) ? 32'd1 : 32'd0);
            chk("one_act", 32'(act1), 32'd0);
        end
        chk("one_pulses", 32'(pulses), 32'd2);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 12'(800 + i), 3'b110);
            chk("one_notready", 32'(wr_en1), 32'd0);
        end
`ifdef FRAME_DROP_CNT_EN
        chk("one_drop_count", 32'(drop1), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
